// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, SRAM and counter signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int N_param = 32,
  parameter int ADDR_W  = 32
);
  logic                   if_req;
  logic [ADDR_W-1:0]      if_addr;
  logic                   if_gnt;
  logic                   if_rvalid;
  logic [N_param-1:0]     if_rdata;

  logic                   ls_req;
  logic [N_param/8-1:0]   ls_we;
  logic [ADDR_W-1:0]      ls_addr;
  logic [N_param-1:0]     ls_wdata;
  logic                   ls_gnt;
  logic                   ls_rvalid;
  logic [N_param-1:0]     ls_rdata;

  logic                   mem_en;
  logic [N_param/8-1:0]   mem_we;
  logic [ADDR_W-3:0]      mem_addr;
  logic [N_param-1:0]     mem_wdata;
  logic [N_param-1:0]     mem_rdata;

  logic [31:0]            conflict_count;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, conflict_count
  );

  // Requester / SRAM side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, conflict_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for a single-port unified SRAM
module mem_port_arbiter #(
  parameter int N_param    = 32,
  parameter int ADDR_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  owner_t      owner_q;
  logic [3:0]  streak_q;
  logic [31:0] conflict_q;

  logic at_limit;
  logic ls_win;
  logic if_win;
  logic unused_addr_lsbs;

  // Fetch only beats load/store once load/store has won STREAK_MAX times in a row over it
  assign at_limit = (streak_q == 4'(STREAK_MAX));
  assign ls_win   = reset & bus.ls_req & ~(bus.if_req & at_limit);
  assign if_win   = reset & bus.if_req & ~ls_win;

  assign bus.if_gnt = if_win;
  assign bus.ls_gnt = ls_win;

  // SRAM request comes straight from the winner; byte offset bits are dropped silently
  assign bus.mem_en    = if_win | ls_win;
  assign bus.mem_addr  = if_win ? bus.if_addr[ADDR_W-1:2] : bus.ls_addr[ADDR_W-1:2];
  assign bus.mem_we    = ls_win ? bus.ls_we : '0;
  assign bus.mem_wdata = ls_win ? bus.ls_wdata : '0;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

  // Read data is shared; rvalid tells each port whether it owns this cycle's word
  assign bus.if_rvalid = (owner_q == OWN_IF);
  assign bus.ls_rvalid = (owner_q == OWN_LS);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

  assign bus.conflict_count = conflict_q;

  // Track the access owner, the load/store winning streak and the saturating conflict count
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      streak_q   <= 4'd0;
      conflict_q <= 32'd0;
    end else begin
      if (if_win)
        owner_q <= OWN_IF;
      else if (ls_win)
        owner_q <= OWN_LS;
      else
        owner_q <= OWN_NONE;

      // ls winning with fetch waiting implies the streak is below the limit
      if (ls_win && bus.if_req)
        streak_q <= streak_q + 4'd1;
      else
        streak_q <= 4'd0;

      if (bus.if_req && bus.ls_req && (conflict_q != 32'hFFFF_FFFF))
        conflict_q <= conflict_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table and response scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic tb_clk = 1'b0;
  logic reset;

  always #5 tb_clk = ~tb_clk;

  mem_port_arbiter_if #(.N_param(32), .ADDR_W(32)) bus ();

  mem_port_arbiter #(.N_param(32), .ADDR_W(32), .STREAK_MAX(4)) dut (
    .clk   (tb_clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [3:0]  ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic [29:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic        is_ls;
    logic        chk_data;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  resp_t       sb [$];
  vec_t        vt [$];
  int          total = 0;
  int          bad   = 0;

  // SRAM model: registered read, byte-masked write
  always @(posedge tb_clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr,
                              input logic [3:0] lwe, input logic [31:0] la,
                              input logic [31:0] lwd, input logic eif, input logic els);
    vec_t v;
    v.if_req   = ir;
    v.if_addr  = ia;
    v.ls_req   = lr;
    v.ls_we    = lwe;
    v.ls_addr  = la;
    v.ls_wdata = lwd;
    v.e_if_gnt = eif;
    v.e_ls_gnt = els;
    v.e_addr   = eif ? ia[31:2] : la[31:2];
    v.e_we     = els ? lwe : 4'h0;
    v.e_wdata  = els ? lwd : 32'h0;
    return v;
  endfunction

  task automatic check_resp();
    resp_t       e;
    logic [1:0]  exp_rv;
    exp_rv = 2'b00;
    if (sb.size() != 0) exp_rv = sb[0].is_ls ? 2'b01 : 2'b10;
    chk("rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      e = sb.pop_front();
      if (e.chk_data)
        chk(e.is_ls ? "ls_rdata" : "if_rdata", e.is_ls ? bus.ls_rdata : bus.if_rdata, e.data);
    end
  endtask

  // Drive one cycle of requests, check the grant side, score the expected response, then check it
  task automatic apply_vec(input vec_t v);
    resp_t r;
    int    idx;
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.ls_req   = v.ls_req;
    bus.ls_we    = v.ls_we;
    bus.ls_addr  = v.ls_addr;
    bus.ls_wdata = v.ls_wdata;
    #1;
    chk("if_gnt", 32'(bus.if_gnt), 32'(v.e_if_gnt));
    chk("ls_gnt", 32'(bus.ls_gnt), 32'(v.e_ls_gnt));
    chk("mem_en", 32'(bus.mem_en), 32'(v.e_if_gnt | v.e_ls_gnt));
    if (v.e_if_gnt || v.e_ls_gnt) begin
      chk("mem_addr",  32'(bus.mem_addr), 32'(v.e_addr));
      chk("mem_we",    32'(bus.mem_we),   32'(v.e_we));
      chk("mem_wdata", bus.mem_wdata,     v.e_wdata);
    end
    if (v.e_if_gnt) begin
      r.is_ls = 1'b0; r.chk_data = 1'b1; r.data = ref_mem[v.if_addr[9:2]];
      sb.push_back(r);
    end
    if (v.e_ls_gnt) begin
      idx = int'(v.ls_addr[9:2]);
      r.is_ls = 1'b1;
      if (v.ls_we == 4'h0) begin
        r.chk_data = 1'b1; r.data = ref_mem[idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (v.ls_we[b]) ref_mem[idx][8*b +: 8] = v.ls_wdata[8*b +: 8];
        r.chk_data = 1'b0; r.data = 32'h0;
      end
      sb.push_back(r);
    end
    @(posedge tb_clk);
    @(negedge tb_clk);
    check_resp();
  endtask

  localparam int N_BASIC = 9;
  localparam int N_CONF  = 10;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    bus.mem_rdata = 32'h0;

    // Fetch alone, ls_we ignored when ls_req is low, store/load incl. partial store and misaligned load, idle
    vt.push_back(mk(1, 32'h0,  0, 4'h0, 32'h0,   32'h0,         1, 0));
    vt.push_back(mk(1, 32'h4,  0, 4'h0, 32'h0,   32'h0,         1, 0));
    vt.push_back(mk(1, 32'h8,  0, 4'h0, 32'h0,   32'h0,         1, 0));
    vt.push_back(mk(1, 32'hC,  0, 4'hF, 32'h200, 32'h1234_5678, 1, 0));
    vt.push_back(mk(0, 32'h0,  1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 1));
    vt.push_back(mk(0, 32'h0,  1, 4'h0, 32'h100, 32'h0,         0, 1));
    vt.push_back(mk(0, 32'h0,  1, 4'h3, 32'h100, 32'h0000_CAFE, 0, 1));
    vt.push_back(mk(0, 32'h0,  1, 4'h0, 32'h103, 32'h0,         0, 1));
    vt.push_back(mk(0, 32'h0,  0, 4'h0, 32'h0,   32'h0,         0, 0));
    // Ten-cycle conflict: LS x4, IF, LS x4, IF
    for (int i = 0; i < N_CONF; i++)
      vt.push_back(mk(1, 32'h0C, 1, 4'h0, 32'h10, 32'h0, (i % 5) == 4, (i % 5) != 4));
    // Single conflict then fetch alone
    vt.push_back(mk(1, 32'h14, 1, 4'h0, 32'h18, 32'h0, 0, 1));
    vt.push_back(mk(1, 32'h14, 0, 4'h0, 32'h0,  32'h0, 1, 0));

    // Reset with both requests high: no grants, clean state
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.ls_req = 1'b1; bus.ls_we = 4'h0; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
    @(negedge tb_clk);
    #1;
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge tb_clk);
    chk("rst_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
    chk("rst_conflict", bus.conflict_count, 32'd0);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply_vec(vt[i]);
      if (i == N_BASIC - 1)           chk("conflict_after_basic", bus.conflict_count, 32'd0);
      if (i == N_BASIC + N_CONF - 1)  chk("conflict_after_10",    bus.conflict_count, 32'd10);
      if (i == N_BASIC + N_CONF + 1)  chk("conflict_after_single", bus.conflict_count, 32'd11);
    end

    // Reset mid-flight: load granted in a conflict, then reset asserted with both requests held
    apply_vec(mk(1, 32'h14, 1, 4'h0, 32'h100, 32'h0, 0, 1));
    chk("streak_pre_reset", 32'(dut.streak_q), 32'd1);
    reset = 1'b0;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    #1;
    chk("mid_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("mid_rst_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("conflict_pre_reset", bus.conflict_count, 32'd12);
    @(posedge tb_clk);
    @(negedge tb_clk);
    chk("mid_rst_rvalid",   32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
    chk("mid_rst_streak",   32'(dut.streak_q), 32'd0);
    chk("mid_rst_conflict", bus.conflict_count, 32'd0);
    chk("mid_rst_gnt",      32'({bus.if_gnt, bus.ls_gnt}), 32'd0);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    reset = 1'b1;
    @(negedge tb_clk);

    // Saturation of the conflict counter
    force dut.conflict_q = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_q;
    chk("sat_preset", bus.conflict_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      apply_vec(mk(1, 32'h0, 1, 4'h0, 32'h4, 32'h0, 0, 1));
      chk("sat_conflict", bus.conflict_count, 32'hFFFF_FFFF);
    end
    apply_vec(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
